// File: rtl/pseudo_color_lut_if.sv
// pseudo_color_lut_if
// Bundles the pixel, configuration and frame-sync signals of
// pseudo_color_lut_ctrl.
//   slave  : the palette controller
//   master : host/pipeline side driving it
// Signals:
//   frame_start_i               frame-start (vsync) pulse
//   cfg_wr_i/cfg_addr_i/cfg_data_i/cfg_ready_o   shadow-bank write handshake
//   cfg_commit_i, cfg_busy_o    swap request / controller busy (INIT or PEND)
//   pix_valid_i, data_lut_i     pixel qualifier and palette index
//   pix_valid_o, y/u/v_data_o   palette result, one cycle later
//   active_bank_o, swap_done_o  bank status and swap pulse
// Optional macro PSEUDO_COLOR_BYPASS_EN adds bypass_i (sampled with data_lut_i).
`timescale 1ns/1ps
interface pseudo_color_lut_if #(
  parameter int PIXEL_DATA_W = 8,
  parameter int DETAIL_LUT_W = 3,
  parameter int Y_DATA_W     = 8,
  parameter int U_DATA_W     = 8,
  parameter int V_DATA_W     = 8
) ();
  localparam int DATA_LUT_W = PIXEL_DATA_W + DETAIL_LUT_W;
  localparam int YUV_DATA_W = Y_DATA_W + U_DATA_W + V_DATA_W;

  logic                  frame_start_i;
  logic                  cfg_wr_i;
  logic [DATA_LUT_W-1:0] cfg_addr_i;
  logic [YUV_DATA_W-1:0] cfg_data_i;
  logic                  cfg_ready_o;
  logic                  cfg_commit_i;
  logic                  cfg_busy_o;
  logic                  pix_valid_i;
  logic [DATA_LUT_W-1:0] data_lut_i;
  logic                  pix_valid_o;
  logic [Y_DATA_W-1:0]   y_data_o;
  logic [U_DATA_W-1:0]   u_data_o;
  logic [V_DATA_W-1:0]   v_data_o;
  logic                  active_bank_o;
  logic                  swap_done_o;
`ifdef PSEUDO_COLOR_BYPASS_EN
  logic                  bypass_i;
`endif

  modport slave (
`ifdef PSEUDO_COLOR_BYPASS_EN
    input  bypass_i,
`endif
    input  frame_start_i, cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i,
    input  pix_valid_i, data_lut_i,
    output cfg_ready_o, cfg_busy_o, pix_valid_o, y_data_o, u_data_o, v_data_o,
    output active_bank_o, swap_done_o
  );

  modport master (
`ifdef PSEUDO_COLOR_BYPASS_EN
    output bypass_i,
`endif
    output frame_start_i, cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i,
    output pix_valid_i, data_lut_i,
    input  cfg_ready_o, cfg_busy_o, pix_valid_o, y_data_o, u_data_o, v_data_o,
    input  active_bank_o, swap_done_o
  );
endinterface

// File: rtl/pseudo_color_lut_ctrl.sv
// pseudo_color_lut_ctrl
// Owns the double-banked gray-to-YUV pseudo-color palette RAM. The active
// bank feeds the pixel datapath; the shadow bank takes host writes. A commit
// swaps the banks at the next frame start so no frame mixes palettes. After
// reset both banks are filled with a grayscale default palette (INIT).
// Ports:
//   clk_i  single clock
//   rst_i  synchronous, active-high reset
//   bus    pseudo_color_lut_if.slave (config handshake, pixel in/out, status)
// Optional macro PSEUDO_COLOR_BYPASS_EN: bus.bypass_i selects a grayscale
// passthrough of data_lut_i with the same one-cycle latency as the RAM path.
`timescale 1ns/1ps
module pseudo_color_lut_ctrl #(
  parameter int PIXEL_DATA_W = 8,
  parameter int DETAIL_LUT_W = 3,
  parameter int Y_DATA_W     = 8,
  parameter int U_DATA_W     = 8,
  parameter int V_DATA_W     = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  pseudo_color_lut_if.slave  bus
);
  localparam int DATA_LUT_W = PIXEL_DATA_W + DETAIL_LUT_W;
  localparam int YUV_DATA_W = Y_DATA_W + U_DATA_W + V_DATA_W;
  localparam int DEPTH      = 1 << DATA_LUT_W;
  localparam int RAM_AW     = DATA_LUT_W + 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [U_DATA_W-1:0] U_MID = {1'b1, {(U_DATA_W-1){1'b0}}};
  localparam logic [V_DATA_W-1:0] V_MID = {1'b1, {(V_DATA_W-1){1'b0}}};

  // Gray level to Y: keep the MSBs when Y is narrower, zero-extend when wider.
  function automatic logic [Y_DATA_W-1:0] gray_to_y(input logic [PIXEL_DATA_W-1:0] pix);
    logic [Y_DATA_W-1:0] y;
    y = '0;
    for (int i = 0; i < Y_DATA_W; i++) begin
      if (Y_DATA_W <= PIXEL_DATA_W)
        y[i] = pix[PIXEL_DATA_W-Y_DATA_W+i];
      else if (i < PIXEL_DATA_W)
        y[i] = pix[i];
    end
    return y;
  endfunction

  function automatic logic [YUV_DATA_W-1:0] default_entry(input logic [DATA_LUT_W-1:0] idx);
    return {gray_to_y(idx[DATA_LUT_W-1 -: PIXEL_DATA_W]), U_MID, V_MID};
  endfunction

  logic [1:0]            state;
  logic                  active_bank;
  logic                  swap_done;
  logic [RAM_AW-1:0]     init_cnt;

  logic                  we;
  logic [RAM_AW-1:0]     waddr;
  logic [YUV_DATA_W-1:0] wdata;

  logic [YUV_DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [YUV_DATA_W-1:0] rd_yuv_p1;
  logic                  vld_p1;
  logic                  force_p1;

  // Control FSM: INIT fills both banks, IDLE takes shadow writes, PEND waits
  // for the frame start that performs the swap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_INIT;
      active_bank <= 1'b0;
      init_cnt    <= '0;
      swap_done   <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.cfg_commit_i) state <= ST_PEND;
        end
        ST_PEND: begin
          if (bus.frame_start_i) begin
            active_bank <= ~active_bank;
            swap_done   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Single RAM write port: INIT fill has the port to itself; afterwards only
  // accepted host writes reach it, always into the shadow bank.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state == ST_INIT) begin
      we    = 1'b1;
      waddr = init_cnt;
      wdata = default_entry(init_cnt[DATA_LUT_W-1:0]);
    end else if (state == ST_IDLE && bus.cfg_wr_i) begin
      we    = 1'b1;
      waddr = {~active_bank, bus.cfg_addr_i};
      wdata = bus.cfg_data_i;
    end
  end

  // ---- stage p0 -> p1: RAM access (read every cycle) ----
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rd_yuv_p1 <= mem[{active_bank, bus.data_lut_i}];
  end

  // Output qualifiers are reset so the outputs show the forced INIT value
  // straight out of reset even though the RAM read register is not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      force_p1 <= 1'b1;
    end else begin
      vld_p1   <= bus.pix_valid_i;
      force_p1 <= (state == ST_INIT);
    end
  end

`ifdef PSEUDO_COLOR_BYPASS_EN
  logic                byp_p1;
  logic [Y_DATA_W-1:0] byp_y_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) byp_p1 <= 1'b0;
    else       byp_p1 <= bus.bypass_i;
  end

  always_ff @(posedge clk_i) begin
    byp_y_p1 <= gray_to_y(bus.data_lut_i[DATA_LUT_W-1 -: PIXEL_DATA_W]);
  end
`endif

  // ---- stage p1: output select ----
  always_comb begin
    bus.y_data_o = rd_yuv_p1[YUV_DATA_W-1 -: Y_DATA_W];
    bus.u_data_o = rd_yuv_p1[U_DATA_W+V_DATA_W-1 -: U_DATA_W];
    bus.v_data_o = rd_yuv_p1[V_DATA_W-1:0];
    if (force_p1) begin
      bus.y_data_o = '0;
      bus.u_data_o = U_MID;
      bus.v_data_o = V_MID;
    end
`ifdef PSEUDO_COLOR_BYPASS_EN
    if (byp_p1) begin
      bus.y_data_o = byp_y_p1;
      bus.u_data_o = U_MID;
      bus.v_data_o = V_MID;
    end
`endif
  end

  assign bus.pix_valid_o   = vld_p1;
  assign bus.cfg_ready_o   = (state == ST_IDLE);
  assign bus.cfg_busy_o    = (state != ST_IDLE);
  assign bus.active_bank_o = active_bank;
  assign bus.swap_done_o   = swap_done;

endmodule

// File: tb/tb_pseudo_color_lut_ctrl.sv
`timescale 1ns/1ps
module tb_pseudo_color_lut_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pseudo_color_lut_if #(.PIXEL_DATA_W(8), .DETAIL_LUT_W(3), .Y_DATA_W(8),
                        .U_DATA_W(8), .V_DATA_W(8)) bus ();

  pseudo_color_lut_ctrl #(.PIXEL_DATA_W(8), .DETAIL_LUT_W(3), .Y_DATA_W(8),
                          .U_DATA_W(8), .V_DATA_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_q [$];
  logic [23:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one pixel read and queue the YUV expected one cycle later.
  task automatic pix(input logic [10:0] addr, input logic [23:0] yuv);
    bus.pix_valid_i = 1'b1;
    bus.data_lut_i  = addr;
    exp_q.push_back(yuv);
    step();
    bus.pix_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [10:0] addr, input logic [23:0] data);
    bus.cfg_wr_i   = 1'b1;
    bus.cfg_addr_i = addr;
    bus.cfg_data_i = data;
    step();
    bus.cfg_wr_i   = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit_i = 1'b1;
    step();
    bus.cfg_commit_i = 1'b0;
  endtask

  task automatic fs_pulse();
    bus.frame_start_i = 1'b1;
    step();
    bus.frame_start_i = 1'b0;
  endtask

  // Counts busy cycles after reset release; one read mid-INIT must be forced.
  task automatic init_wait(input string tag);
    int cnt = 0;
    bit bad = 1'b0;
    while (bus.cfg_busy_o === 1'b1 && cnt < 5000) begin
      if (bus.cfg_ready_o !== 1'b0) bad = 1'b1;
      cnt++;
      if (cnt == 10) begin
        bus.pix_valid_i = 1'b1;
        bus.data_lut_i  = 11'h7F8;
        exp_q.push_back(24'h008080);
      end else begin
        bus.pix_valid_i = 1'b0;
      end
      step();
    end
    bus.pix_valid_i = 1'b0;
    check({tag, "_busy_cycles"}, cnt, 4096);
    check({tag, "_ready_low_in_init"}, {31'd0, bad}, 0);
    check({tag, "_ready_after_init"}, {31'd0, bus.cfg_ready_o}, 1);
  endtask

  // Scoreboard monitor: every presented pixel must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.pix_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pix_yuv", {8'd0, bus.y_data_o, bus.u_data_o, bus.v_data_o}, {8'd0, mon_exp});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start_i = 1'b0;
    bus.cfg_wr_i      = 1'b0;
    bus.cfg_addr_i    = '0;
    bus.cfg_data_i    = '0;
    bus.cfg_commit_i  = 1'b0;
    bus.pix_valid_i   = 1'b0;
    bus.data_lut_i    = '0;

    // Reset state
    step();
    step();
    check("rst_ready",     {31'd0, bus.cfg_ready_o},   0);
    check("rst_busy",      {31'd0, bus.cfg_busy_o},    1);
    check("rst_swap_done", {31'd0, bus.swap_done_o},   0);
    check("rst_pix_valid", {31'd0, bus.pix_valid_o},   0);
    check("rst_bank",      {31'd0, bus.active_bank_o}, 0);
    check("rst_yuv", {8'd0, bus.y_data_o, bus.u_data_o, bus.v_data_o}, 32'h008080);
    rst = 1'b0;

    // INIT length and default grayscale palette
    init_wait("init1");
    pix(11'h7F8, 24'hFF8080);
    pix(11'h203, 24'h408080);
    pix(11'h000, 24'h008080);

    // Write shadow, commit, swap at frame start
    cfg_write(11'h400, 24'h4C55FF);
    commit();
    check("pend_busy",  {31'd0, bus.cfg_busy_o},  1);
    check("pend_ready", {31'd0, bus.cfg_ready_o}, 0);
    pix(11'h400, 24'h808080);
    step();
    fs_pulse();
    check("swap1_done", {31'd0, bus.swap_done_o},   1);
    check("swap1_bank", {31'd0, bus.active_bank_o}, 1);
    pix(11'h400, 24'h4C55FF);
    check("swap1_done_pulse", {31'd0, bus.swap_done_o}, 0);
    check("idle_busy",        {31'd0, bus.cfg_busy_o},  0);

    // Commit together with frame start: swap deferred to the next frame
    cfg_write(11'h010, 24'h123456);
    bus.cfg_commit_i  = 1'b1;
    bus.frame_start_i = 1'b1;
    step();
    bus.cfg_commit_i  = 1'b0;
    bus.frame_start_i = 1'b0;
    check("same_cycle_no_swap", {31'd0, bus.swap_done_o},   0);
    check("same_cycle_bank",    {31'd0, bus.active_bank_o}, 1);
    step();
    step();
    fs_pulse();
    check("swap2_done", {31'd0, bus.swap_done_o},   1);
    check("swap2_bank", {31'd0, bus.active_bank_o}, 0);
    pix(11'h010, 24'h123456);

    // Writes during PEND are dropped
    cfg_write(11'h055, 24'hAABBCC);
    commit();
    check("pend2_ready", {31'd0, bus.cfg_ready_o}, 0);
    cfg_write(11'h055, 24'h112233);
    fs_pulse();
    check("swap3_bank", {31'd0, bus.active_bank_o}, 1);
    pix(11'h055, 24'hAABBCC);

    // Reset while PEND with bank 1 active
    commit();
    check("pend3_busy", {31'd0, bus.cfg_busy_o}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_bank",  {31'd0, bus.active_bank_o}, 0);
    check("rst2_busy",  {31'd0, bus.cfg_busy_o},    1);
    init_wait("init2");
    fs_pulse();
    check("rst2_no_swap", {31'd0, bus.swap_done_o},   0);
    check("rst2_bank_kept", {31'd0, bus.active_bank_o}, 0);
    pix(11'h400, 24'h808080);
    pix(11'h055, 24'h0A8080);

    step();
    step();
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pseudo_color_lut_ctrl.md
Name: pseudo_color_lut_ctrl

Overview:
- Owns the gray-to-YUV pseudo-color palette RAM and sequences every access to it.
- Holds two banks: one active bank serves the pixel datapath, one shadow bank is written by the host configuration port.
- A committed palette swaps in only at a frame boundary, so a frame never shows a mixed palette.
- Sits between the fusion pixel pipeline and the register/config interface. After reset it loads a grayscale default palette itself.

Parameters:
- PIXEL_DATA_W, 8, pixel gray bits.
- DETAIL_LUT_W, 3, detail index bits appended below the pixel bits.
- Y_DATA_W, 8, Y width.
- U_DATA_W, 8, U width.
- V_DATA_W, 8, V width.
- Derived (localparam): DATA_LUT_W = PIXEL_DATA_W+DETAIL_LUT_W; YUV_DATA_W = Y+U+V widths; DEPTH = 2^DATA_LUT_W.

Ports:
- clk_i, in, 1, single clock.
- rst_i, in, 1, reset.
- frame_start_i, in, 1, one-cycle pulse at frame start (vsync).
- cfg_wr_i, in, 1, host write request.
- cfg_addr_i, in, DATA_LUT_W, palette entry address.
- cfg_data_i, in, YUV_DATA_W, entry value packed {Y,U,V}, Y in the MSBs.
- cfg_ready_o, out, 1, write accepted when cfg_wr_i && cfg_ready_o.
- cfg_commit_i, in, 1, request a shadow/active swap at the next frame start.
- cfg_busy_o, out, 1, high in INIT or PEND.
- pix_valid_i, in, 1, pixel qualifier.
- data_lut_i, in, DATA_LUT_W, palette index.
- pix_valid_o, out, 1, pix_valid_i delayed 1 cycle.
- y_data_o, out, Y_DATA_W, Y output.
- u_data_o, out, U_DATA_W, U output.
- v_data_o, out, V_DATA_W, V output.
- active_bank_o, out, 1, bank currently feeding pixels.
- swap_done_o, out, 1, one-cycle pulse on the cycle the swap happens.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=INIT, active_bank_o=0, init counter=0, cfg_ready_o=0, cfg_busy_o=1, swap_done_o=0, pix_valid_o=0, y_data_o=0, u_data_o=v_data_o=1<<(W-1).
- RAM: 2*DEPTH x YUV_DATA_W, inferred block RAM. One write port (bank bit + address), one registered read port. Contents are not reset.
- Pixel read: the read address is {active_bank, data_lut_i}. y/u/v are valid 1 cycle after data_lut_i. The read happens every cycle regardless of pix_valid_i.
- State INIT:
  - A counter of width DATA_LUT_W+1 writes every entry of both banks, one entry per cycle, 2*DEPTH cycles total.
  - Default entry for index a: Y = a[DATA_LUT_W-1 -: Y_DATA_W], zero-extended or truncated if Y_DATA_W differs from PIXEL_DATA_W; U = V = midscale.
  - While in INIT, pixel outputs are forced to Y=0, U=V=midscale.
  - Go to IDLE the cycle after the last write.
- State IDLE:
  - cfg_ready_o=1. An accepted write stores to the shadow bank (~active_bank) at cfg_addr_i.
  - On cfg_commit_i, go to PEND. If cfg_wr_i is high in the same cycle, that write is accepted first.
- State PEND:
  - cfg_ready_o=0. Writes are ignored, not queued.
  - On frame_start_i: toggle active_bank_o, pulse swap_done_o, go to IDLE.
  - Reads issued in the cycle after the frame_start_i pulse use the new bank.
- Boundary cases:
  - frame_start_i in the same cycle as cfg_commit_i (IDLE): no swap; the swap occurs at the next frame_start_i.
  - frame_start_i in INIT or IDLE: no effect.
  - cfg_commit_i in PEND or INIT: ignored.
  - After a swap, the shadow bank holds the previous palette. The host rewrites every entry it needs; there is no automatic copy.
  - rst_i at any time, including mid-INIT or in PEND: restart INIT, active_bank_o=0, any pending commit discarded.
  - cfg_addr_i covers the full range, so there is no out-of-range case.

Optional Feature:
- Macro PSEUDO_COLOR_BYPASS_EN.
- When defined: adds input port bypass_i (1 bit), sampled together with data_lut_i. If bypass_i is high, the outputs one cycle later are Y = data_lut_i[DATA_LUT_W-1 -: Y_DATA_W] and U = V = midscale, same latency as the RAM path. The RAM and FSM are unaffected.
- When undefined: no bypass_i port, and outputs always come from the RAM (or the INIT forcing).

Test Plan:
- Reset for 1 cycle, then idle: cfg_ready_o=0 and cfg_busy_o=1 for exactly 4096 cycles, outputs Y=0x00 U=V=0x80. Then data_lut_i=0x7F8 gives Y=0xFF U=V=0x80 one cycle later, and data_lut_i=0x203 gives Y=0x40.
- Write addr 0x400 data 0x4C55FF, then commit; read 0x400 before frame_start gives 0x80/0x80/0x80. Pulse frame_start_i: swap_done_o=1 and active_bank_o=1; the read of 0x400 on the next cycle gives Y=0x4C U=0x55 V=0xFF.
- cfg_commit_i and frame_start_i in the same cycle: no swap, active_bank_o unchanged. The next frame_start_i swaps.
- cfg_wr_i while in PEND: cfg_ready_o=0; after the swap, the entry holds the previously written value, not the dropped one.
- rst_i asserted in PEND with active_bank_o=1: active_bank_o=0, INIT reruns for 4096 cycles, and no swap_done_o occurs at the next frame_start_i.
- With PSEUDO_COLOR_BYPASS_EN and bypass_i=1, data_lut_i=0x550: Y=0xAA, U=V=0x80 one cycle later, even after a custom palette is committed.
